int_ctrl: RTL and testbench

Interrupt aggregation slave between the SoC interrupt sources (timer0, spare lines) and the core's 8-bit `int_i` input. It latches up to 8 sources as level- or rising-edge-triggered, applies a per-source enable, and drives a registered one-hot vector of the highest-priority pending source to the core. The block is a RIB slave with combinational read data, like the existing timer, uart and gpio slaves. Software completes edge interrupts through a register write.

---
 rtl/int_ctrl.sv | 112 +++++++++++
 tb/tb_int_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Interrupt aggregation slave: level/edge capture of 8 sources, per-source enable,
// fixed lowest-index priority, registered one-hot request to the core, RIB register port.
module int_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic [7:0]  src_i,
  output logic [7:0]  int_o
);

  localparam logic [7:0] ADDR_PENDING = 8'h00;
  localparam logic [7:0] ADDR_ENABLE  = 8'h04;
  localparam logic [7:0] ADDR_TRIG    = 8'h08;
  localparam logic [7:0] ADDR_CLAIM   = 8'h0C;

  logic [7:0] r_enable;
  logic [7:0] r_trig;
  logic [7:0] r_prev;
  logic [7:0] r_epend;
  logic [7:0] r_int;

  logic [7:0] w_addr;
  logic       w_wr_enable;
  logic       w_wr_trig;
  logic       w_complete_hit;
  logic [7:0] w_complete_vec;
  logic [7:0] w_rise;
  logic [7:0] w_pend;
  logic [7:0] w_act;
  logic [7:0] w_sel;
  logic [3:0] w_claim_id;
  logic       w_unused_addr;

  assign w_addr        = addr_i[7:0];
  assign w_unused_addr = ^addr_i[31:8];

  assign w_wr_enable    = we_i && (w_addr == ADDR_ENABLE);
  assign w_wr_trig      = we_i && (w_addr == ADDR_TRIG);
  // Out-of-range ids (0 or above 8, any upper bits set) must not clear anything.
  assign w_complete_hit = we_i && (w_addr == ADDR_CLAIM) &&
                          (data_i >= 32'd1) && (data_i <= 32'd8);

  assign w_rise = src_i & ~r_prev;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_src
      assign w_complete_vec[gi] = w_complete_hit && (data_i[3:0] == 4'(gi + 1));
      assign w_pend[gi]         = r_trig[gi] ? r_epend[gi] : src_i[gi];

      // A rise in the same cycle as its COMPLETE keeps the request alive.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_epend[gi] <= 1'b0;
        end else if (!r_trig[gi]) begin
          r_epend[gi] <= 1'b0;
        end else if (w_rise[gi]) begin
          r_epend[gi] <= 1'b1;
        end else if (w_complete_vec[gi]) begin
          r_epend[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign w_act = w_pend & r_enable;
  assign w_sel = w_act & (~w_act + 8'd1);

  always_comb begin
    w_claim_id = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_act[i]) begin
        w_claim_id = 4'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enable <= 8'h00;
      r_trig   <= 8'h00;
      r_prev   <= 8'h00;
      r_int    <= 8'h00;
    end else begin
      r_prev <= src_i;
      r_int  <= w_sel;
      if (w_wr_enable) begin
        r_enable <= data_i[7:0];
      end
      if (w_wr_trig) begin
        r_trig <= data_i[7:0];
      end
    end
  end

  assign int_o = r_int;

  always_comb begin
    data_o = 32'h0;
    case (w_addr)
      ADDR_PENDING: data_o = {24'h0, w_pend};
      ADDR_ENABLE:  data_o = {24'h0, r_enable};
      ADDR_TRIG:    data_o = {24'h0, r_trig};
      ADDR_CLAIM:   data_o = {28'h0, w_claim_id};
      default:      data_o = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: hand-computed vector table over the documented scenarios, then
// randomized traffic compared against a behavioural model of the pending/priority rules.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] data_i = 32'h0;
  logic [7:0]  src_i = 8'h0;
  logic [31:0] data_o;
  logic [7:0]  int_o;

  int_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .we_i   (we_i),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .src_i  (src_i),
    .int_o  (int_o)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [7:0]  src;
    logic [31:0] exp_rd;
    logic [7:0]  exp_int;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic we, input logic [7:0] a, input logic [31:0] d,
                             input logic [7:0] s, input logic [31:0] r, input logic [7:0] i);
    v = '{we, a, d, s, r, i};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Called just after a rising edge: drive, sample read data, clock, sample int_o.
  task automatic apply(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic [7:0] src, output logic [31:0] rd, output logic [7:0] iv);
    we_i   = we;
    addr_i = addr;
    data_i = data;
    src_i  = src;
    #1 rd = data_o;
    @(posedge clk);
    #1 iv = int_o;
  endtask

  // Behavioural model: what software sees, derived from the pending/priority rules.
  bit [7:0] m_en, m_trig, m_epend, m_prev, m_int;

  function automatic bit [7:0] m_pending(input bit [7:0] src);
    bit [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = m_trig[i] ? m_epend[i] : src[i];
    return p;
  endfunction

  function automatic int m_winner(input bit [7:0] act);
    for (int i = 0; i < 8; i++) if (act[i]) return i + 1;
    return 0;
  endfunction

  function automatic bit [31:0] m_read(input bit [7:0] a, input bit [7:0] src);
    case (a)
      8'h00:   return {24'h0, m_pending(src)};
      8'h04:   return {24'h0, m_en};
      8'h08:   return {24'h0, m_trig};
      8'h0C:   return 32'(m_winner(m_pending(src) & m_en));
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_clock(input bit we, input bit [7:0] a, input bit [31:0] d, input bit [7:0] src);
    int w;
    bit [7:0] ne;
    w = m_winner(m_pending(src) & m_en);
    m_int = (w == 0) ? 8'h00 : 8'(1 << (w - 1));
    for (int i = 0; i < 8; i++) begin
      if (!m_trig[i])                    ne[i] = 1'b0;
      else if (src[i] && !m_prev[i])     ne[i] = 1'b1;
      else if (we && a == 8'h0C && d == 32'(i + 1)) ne[i] = 1'b0;
      else                               ne[i] = m_epend[i];
    end
    m_epend = ne;
    if (we && a == 8'h04) m_en   = d[7:0];
    if (we && a == 8'h08) m_trig = d[7:0];
    m_prev = src;
  endtask

  task automatic m_reset();
    m_en = 0; m_trig = 0; m_epend = 0; m_prev = 0; m_int = 0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset(input string name);
    we_i   = 1'b0;
    addr_i = 32'h4;
    #1 rst = 1'b1;
    #1;
    check({name, " int_o async"}, {24'h0, int_o}, 32'h0);
    check({name, " ENABLE async"}, data_o, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  iv;
    logic [7:0]  src;
    logic [7:0]  a;
    logic [31:0] d;
    logic        we;
    logic [31:0] exp_rd;

    // reset reads / PENDING follows src while TRIG=0
    tbl.push_back(v(0, 8'h04, 0, 8'h00, 32'h0, 8'h00));
    tbl.push_back(v(0, 8'h08, 0, 8'h00, 32'h0, 8'h00));
    tbl.push_back(v(0, 8'h0C, 0, 8'h00, 32'h0, 8'h00));
    tbl.push_back(v(0, 8'h00, 0, 8'h5A, 32'h5A, 8'h00));
    // level source 0
    tbl.push_back(v(1, 8'h04, 32'h01, 8'h00, 32'h0, 8'h00));
    tbl.push_back(v(0, 8'h04, 0, 8'h01, 32'h01, 8'h01));
    tbl.push_back(v(0, 8'h0C, 0, 8'h01, 32'h1, 8'h01));
    tbl.push_back(v(1, 8'h0C, 32'h1, 8'h01, 32'h1, 8'h01));
    tbl.push_back(v(0, 8'h00, 0, 8'h00, 32'h0, 8'h00));
    // edge source 2
    tbl.push_back(v(1, 8'h08, 32'h04, 8'h00, 32'h0, 8'h00));
    tbl.push_back(v(1, 8'h04, 32'h04, 8'h00, 32'h01, 8'h00));
    tbl.push_back(v(0, 8'h00, 0, 8'h04, 32'h0, 8'h00));
    tbl.push_back(v(0, 8'h00, 0, 8'h00, 32'h04, 8'h04));
    tbl.push_back(v(0, 8'h0C, 0, 8'h00, 32'h3, 8'h04));
    tbl.push_back(v(1, 8'h0C, 32'h3, 8'h00, 32'h3, 8'h04));
    tbl.push_back(v(0, 8'h0C, 0, 8'h00, 32'h0, 8'h00));
    // simultaneous rises on 1 and 5
    tbl.push_back(v(1, 8'h08, 32'hFF, 8'h00, 32'h04, 8'h00));
    tbl.push_back(v(1, 8'h04, 32'hFF, 8'h00, 32'h04, 8'h00));
    tbl.push_back(v(0, 8'h00, 0, 8'h22, 32'h0, 8'h00));
    tbl.push_back(v(0, 8'h0C, 0, 8'h00, 32'h2, 8'h02));
    tbl.push_back(v(1, 8'h0C, 32'h2, 8'h00, 32'h2, 8'h02));
    tbl.push_back(v(0, 8'h0C, 0, 8'h00, 32'h6, 8'h20));
    tbl.push_back(v(1, 8'h0C, 32'h6, 8'h00, 32'h6, 8'h20));
    tbl.push_back(v(0, 8'h0C, 0, 8'h00, 32'h0, 8'h00));
    // rise and COMPLETE of id 1 in the same cycle
    tbl.push_back(v(0, 8'h00, 0, 8'h01, 32'h0, 8'h00));
    tbl.push_back(v(0, 8'h00, 0, 8'h00, 32'h01, 8'h01));
    tbl.push_back(v(1, 8'h0C, 32'h1, 8'h01, 32'h1, 8'h01));
    tbl.push_back(v(0, 8'h0C, 0, 8'h00, 32'h1, 8'h01));
    tbl.push_back(v(1, 8'h0C, 32'h1, 8'h00, 32'h1, 8'h01));
    tbl.push_back(v(0, 8'h0C, 0, 8'h00, 32'h0, 8'h00));
    // masked edge source 3, late enable, bogus completes, unmapped offset
    tbl.push_back(v(1, 8'h08, 32'h08, 8'h00, 32'hFF, 8'h00));
    tbl.push_back(v(1, 8'h04, 32'h00, 8'h00, 32'hFF, 8'h00));
    tbl.push_back(v(0, 8'h00, 0, 8'h08, 32'h0, 8'h00));
    tbl.push_back(v(0, 8'h00, 0, 8'h00, 32'h08, 8'h00));
    tbl.push_back(v(0, 8'h0C, 0, 8'h00, 32'h0, 8'h00));
    tbl.push_back(v(1, 8'h04, 32'h08, 8'h00, 32'h0, 8'h00));
    tbl.push_back(v(0, 8'h0C, 0, 8'h00, 32'h4, 8'h08));
    tbl.push_back(v(1, 8'h0C, 32'h0, 8'h00, 32'h4, 8'h08));
    tbl.push_back(v(1, 8'h0C, 32'h9, 8'h00, 32'h4, 8'h08));
    tbl.push_back(v(1, 8'h10, 32'hFF, 8'h00, 32'h0, 8'h08));
    tbl.push_back(v(0, 8'h00, 0, 8'h00, 32'h08, 8'h08));
    // ENABLE cleared while pending: epend retained
    tbl.push_back(v(1, 8'h04, 32'h00, 8'h00, 32'h08, 8'h08));
    tbl.push_back(v(0, 8'h00, 0, 8'h00, 32'h08, 8'h00));
    tbl.push_back(v(1, 8'h04, 32'h08, 8'h00, 32'h0, 8'h00));
    tbl.push_back(v(0, 8'h04, 0, 8'h00, 32'h08, 8'h08));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[k]) begin
      apply(tbl[k].we, {24'hA5A5A5, tbl[k].addr}, tbl[k].data, tbl[k].src, rd, iv);
      $display("vec %0d we=%0b addr=%h data=%h src=%h rd=%h int=%h", k,
               tbl[k].we, tbl[k].addr, tbl[k].data, tbl[k].src, rd, iv);
      check($sformatf("vec%0d data_o", k), rd, tbl[k].exp_rd);
      check($sformatf("vec%0d int_o", k), {24'h0, iv}, {24'h0, tbl[k].exp_int});
    end

    do_reset("midrun_reset");

    src = 8'h00;
    for (int n = 0; n < 800; n++) begin
      if (n == 400) do_reset("random_reset");
      src = src ^ 8'($urandom & $urandom & $urandom);
      we  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0: a = 8'h00;
        1: a = 8'h04;
        2: a = 8'h08;
        3, 4: a = 8'h0C;
        default: a = 8'($urandom);
      endcase
      if (a == 8'h0C && $urandom_range(0, 7) != 0) d = 32'($urandom_range(0, 10));
      else d = $urandom;
      exp_rd = m_read(a, src);
      apply(we, {8'($urandom), 8'($urandom), 8'($urandom), a}, d, src, rd, iv);
      m_clock(we, a, d, src);
      $display("rnd %0d we=%0b addr=%h data=%h src=%h rd=%h int=%h", n, we, a, d, src, rd, iv);
      check($sformatf("rnd%0d data_o", n), rd, exp_rd);
      check($sformatf("rnd%0d int_o", n), {24'h0, iv}, {24'h0, m_int});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
